// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a store-edge-detected push into a circular FIFO.
// One push per store instruction; the frame engine drains the FIFO back-to-back with no idle gap.
module mmio_uart_tx #(
  parameter logic [31:0] UART_ADDR    = 32'h0000_00FC,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemWrite,
  input  logic [31:0]                   DataAdr,
  input  logic [31:0]                   WriteData,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   FULL_N    = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic          wr_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    shift;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic          qualified, push_req, push, pop, baud_end;
  logic          unused_bits;
  assign unused_bits = ^WriteData[31:8];
  assign qualified   = MemWrite && (DataAdr == UART_ADDR);
  assign push_req    = qualified && !wr_q;
  assign push        = push_req && !fifo_full;
  assign baud_end    = baud == BAUD_LAST;
  assign pop         = !fifo_empty && (state == IDLE || (state == STOP && baud_end));
  assign fifo_empty  = fifo_count == '0;
  assign fifo_full   = fifo_count == FULL_N;
  assign busy        = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_q <= qualified;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_req && fifo_full) overflow <= 1'b1;
      if (push && !pop) fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end
  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= WriteData[7:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else baud <= baud + 1'b1;
        end
        DATA: begin
          if (baud_end) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end else baud <= baud + 1'b1;
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            // Chain straight into the next START so queued frames leave no idle gap.
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else state <= IDLE;
          end else baud <= baud + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench with a serial decoder on tx; bytes and frame start cycles are queued.
module tb_mmio_uart_tx;
  logic        clk = 0;
  logic        reset = 1;
  logic        MemWrite = 0;
  logic [31:0] DataAdr = 0;
  logic [31:0] WriteData = 0;
  logic        tx, busy, fifo_empty, fifo_full, overflow;
  logic [3:0]  fifo_count;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_err = 0;
  bit rx_on = 0;
  int rx_cnt = 0;
  int rx_t0 = 0;
  logic [7:0] rx_sh;
  logic [7:0] rx_q[$];
  int rx_t[$];

  mmio_uart_tx #(.UART_ADDR(32'h0000_00FC), .CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .tx(tx), .busy(busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Decoder samples the middle of each 4-cycle bit, counted from the first low sample.
  initial forever begin
    @(negedge clk);
    if (reset) rx_on = 0;
    else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1;
        rx_cnt = 0;
        rx_t0 = cyc;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % 4 == 2) begin
        if (rx_cnt == 2) begin
          if (tx !== 1'b0) frame_err++;
        end else if (rx_cnt < 38) rx_sh[(rx_cnt - 6) / 4] = tx;
        else begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(rx_sh);
          rx_t.push_back(rx_t0);
          rx_on = 0;
        end
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [7:0] d, input int len);
    @(posedge clk);
    #1;
    MemWrite = 1;
    DataAdr = a;
    WriteData = {24'h0, d};
    repeat (len) @(posedge clk);
    #1;
    MemWrite = 0;
  endtask

  task automatic wait_idle(output int peak);
    peak = int'(fifo_count);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (!busy && fifo_empty && !rx_on) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle timeout busy=%b count=%0d", busy, fifo_count);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", fifo_full); end
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset = 0;
  endtask

  task automatic test_single();
    logic [9:0] exp_bits;
    exp_bits = 10'b10_1010_1010;
    rx_q.delete();
    rx_t.delete();
    store(32'hFC, 8'h55, 1);
    checks += 5;
    if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_push_count got %0d want 1", fifo_count); end
    if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_edge1 got %b want 1", tx); end
    @(posedge clk);
    #1;
    if (tx !== 1'b0) begin errors++; $display("FAIL single_tx_edge2 got %b want 0", tx); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_edge2 got %b want 1", busy); end
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", fifo_count); end
    for (int b = 0; b < 10; b++) begin
      repeat (b == 0 ? 2 : 4) @(posedge clk);
      #1;
      checks++;
      if (tx !== exp_bits[b]) begin errors++; $display("FAIL single_bit%0d got %b want %b", b, tx, exp_bits[b]); end
    end
    @(posedge clk);
    #1;
    checks += 5;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_39 got %b want 1", busy); end
    @(posedge clk);
    #1;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_40 got %b want 0", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", fifo_empty); end
    if (rx_q.size() != 1) begin errors++; $display("FAIL single_frames got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== 8'h55) begin errors++; $display("FAIL single_byte got %h want 55", rx_q[0]); end
    if (frame_err != 0) begin errors++; $display("FAIL single_framing got %0d want 0", frame_err); end
  endtask

  task automatic test_addr_filter();
    int peak, p2;
    rx_q.delete();
    rx_t.delete();
    store(32'hF8, 8'hA5, 1);
    checks++;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL filter_other_addr got %0d want 0", fifo_count); end
    @(posedge clk);
    #1;
    MemWrite = 1;
    DataAdr = 32'hFC;
    WriteData = 32'h3C;
    peak = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    MemWrite = 0;
    wait_idle(p2);
    if (p2 > peak) peak = p2;
    checks += 3;
    if (peak != 1) begin errors++; $display("FAIL filter_peak got %0d want 1", peak); end
    if (rx_q.size() != 1) begin errors++; $display("FAIL filter_frames got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== 8'h3C) begin errors++; $display("FAIL filter_byte got %h want 3c", rx_q[0]); end
    if (frame_err != 0) begin errors++; $display("FAIL filter_framing got %0d want 0", frame_err); end
  endtask

  task automatic test_back_to_back();
    int peak;
    rx_q.delete();
    rx_t.delete();
    store(32'hFC, 8'h01, 1);
    store(32'hFC, 8'h02, 1);
    store(32'hFC, 8'h03, 1);
    wait_idle(peak);
    checks++;
    if (rx_q.size() != 3) begin errors++; $display("FAIL b2b_frames got %0d want 3", rx_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, rx_q[i], 8'(i + 1)); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rx_t[i] - rx_t[i-1] != 40) begin errors++; $display("FAIL b2b_gap%0d got %0d want 40", i, rx_t[i] - rx_t[i-1]); end
      end
    end
  endtask

  task automatic test_overflow();
    int peak;
    rx_q.delete();
    rx_t.delete();
    store(32'hFC, 8'h10, 1);
    for (int i = 0; i < 8; i++) store(32'hFC, 8'h20 + 8'(i), 1);
    checks += 6;
    if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count_full got %0d want 8", fifo_count); end
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", fifo_full); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
    store(32'hFC, 8'h28, 1);
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count_after got %0d want 8", fifo_count); end
    wait_idle(peak);
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    checks++;
    if (rx_q.size() != 9) begin errors++; $display("FAIL ovf_frames got %0d want 9", rx_q.size()); end
    else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (rx_q[i] !== (i == 0 ? 8'h10 : 8'h20 + 8'(i - 1)))
          begin errors++; $display("FAIL ovf_byte%0d got %h", i, rx_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0, bad;
    rx_q.delete();
    rx_t.delete();
    store(32'hFC, 8'h07, 1);
    t0 = cyc + 1;
    store(32'hFC, 8'h11, 1);
    store(32'hFC, 8'h22, 1);
    while (cyc < t0 + 17) @(posedge clk);
    #1;
    checks += 8;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_pre_tx got %b want 0", tx); end
    if (fifo_count !== 4'd2) begin errors++; $display("FAIL mid_pre_count got %0d want 2", fifo_count); end
    reset = 1;
    #1;
    if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx got %b want 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fifo_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b want 0", overflow); end
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    bad = 0;
    repeat (120) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    if (bad != 0) begin errors++; $display("FAIL mid_quiet got %0d active cycles want 0", bad); end
    if (rx_q.size() != 0) begin errors++; $display("FAIL mid_frames got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_wrap();
    int peak, p;
    rx_q.delete();
    rx_t.delete();
    peak = 0;
    for (int i = 0; i < 20; i++) begin
      store(32'hFC, 8'(i * 37 + 11), 1);
      wait_idle(p);
      if (p > peak) peak = p;
    end
    checks += 2;
    if (peak > 1) begin errors++; $display("FAIL wrap_peak got %0d want <=1", peak); end
    if (rx_q.size() != 20) begin errors++; $display("FAIL wrap_frames got %0d want 20", rx_q.size()); end
    else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i * 37 + 11)) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", i, rx_q[i], 8'(i * 37 + 11)); end
      end
    end
    checks++;
    if (frame_err != 0) begin errors++; $display("FAIL wrap_framing got %0d want 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_addr_filter();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
